// File: rtl/framebuf_lines.sv
// Line-oriented frame buffer: full-line writes, single-pixel registered reads, one-entry write hazard buffer.
// Optional whole-frame clear sequencer is compiled in when FBUF_CLEAR_EN is defined.
module framebuf_lines #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int BPP  = 1,
  parameter int RW   = 7,
  parameter int CW   = 7
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [RW-1:0]        row,
  input  logic [CW-1:0]        col,
  output logic [BPP-1:0]       data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [RW-1:0]        rowW,
  input  logic [COLS*BPP-1:0]  dataW,
  input  logic                 clear_req,
  output logic                 clear_busy
);

  localparam int LW = COLS * BPP;
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [LW-1:0]  r_mem [ROWS];
  logic           r_pend_valid;
  logic [RW-1:0]  r_pend_row;
  logic [LW-1:0]  r_pend_data;
  logic [RW-1:0]  r_clr_cnt;

  logic           w_row_ok;
  logic           w_col_ok;
  logic           w_rowW_ok;
  logic           w_accept;
  logic           w_commit_pend;
  logic           w_direct;
  logic           w_to_pend;
  logic           w_pend_next_valid;
  logic           w_clr_last;
  logic           w_mem_we;
  logic [AW-1:0]  w_mem_addr;
  logic [LW-1:0]  w_mem_wdata;
  logic [LW-1:0]  w_line;
  logic [LW-1:0]  w_shift;
  logic [BPP-1:0] w_pix;

  assign w_row_ok  = 32'(row)  < ROWS;
  assign w_col_ok  = 32'(col)  < COLS;
  assign w_rowW_ok = 32'(rowW) < ROWS;

  assign wr_ready = !r_pend_valid && (r_state == IDLE);

  // Writes are blocked while reset is held so nothing lands in memory before state is sane.
  assign w_accept          = wr_valid && wr_ready && rstn;
  assign w_commit_pend     = r_pend_valid && (row != r_pend_row);
  assign w_direct          = w_accept && w_rowW_ok && (rowW != row);
  assign w_to_pend         = w_accept && w_rowW_ok && (rowW == row);
  assign w_pend_next_valid = w_to_pend || (r_pend_valid && !w_commit_pend);
  assign w_clr_last        = (r_clr_cnt == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_row   <= '0;
      r_pend_data  <= '0;
    end else if (w_to_pend) begin
      r_pend_valid <= 1'b1;
      r_pend_row   <= rowW;
      r_pend_data  <= dataW;
    end else if (w_commit_pend) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Single memory write port: clear, pending drain and direct writes never coincide.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (r_state == CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_cnt[AW-1:0];
    end else if (w_commit_pend) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_pend_row[AW-1:0];
      w_mem_wdata = r_pend_data;
    end else if (w_direct) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = rowW[AW-1:0];
      w_mem_wdata = dataW;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_line  = r_mem[row[AW-1:0]];
  assign w_shift = w_line >> (32'(col) * BPP);
  assign w_pix   = w_shift[BPP-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
    end else if (w_state_next == CLEAR) begin
      data <= '0;
    end else if (w_row_ok && w_col_ok) begin
      data <= w_pix;
    end else begin
      data <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
    end
  end

`ifdef FBUF_CLEAR_EN
  // A write landing in the pending buffer on the request edge forces a drain first.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (clear_req) w_state_next = w_pend_next_valid ? DRAIN : CLEAR;
      DRAIN:   if (w_commit_pend) w_state_next = CLEAR;
      CLEAR:   if (w_clr_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign clear_busy = (r_state != IDLE);
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_req ^ w_pend_next_valid;
  assign w_state_next   = IDLE;
  assign clear_busy     = 1'b0;
`endif

endmodule

// File: doc/framebuf_lines.md
FRAMEBUF_LINES -- requirements
Module: framebuf_lines

Interface
REQ-001 Parameter COLS, default 80, pixels per line.
REQ-002 Parameter ROWS, default 60, lines per frame.
REQ-003 Parameter BPP, default 1, bits per pixel.
REQ-004 Parameter RW, default 7, row address width (>= clog2(ROWS)).
REQ-005 Parameter CW, default 7, column address width (>= clog2(COLS)).
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 row  in  RW  read line address.
REQ-009 col  in  CW  read pixel address.
REQ-010 data  out  BPP  registered read pixel.
REQ-011 wr_valid  in  1  write request.
REQ-012 wr_ready  out  1  write can be accepted.
REQ-013 rowW  in  RW  line number to write.
REQ-014 dataW  in  COLS*BPP  full line; pixel c at bits [c*BPP +: BPP].
REQ-015 clear_req  in  1  single-cycle request to zero the frame (FBUF_CLEAR_EN only).
REQ-016 clear_busy  out  1  clear sequence in progress (tied 0 without FBUF_CLEAR_EN).

Function
REQ-017 Storage SHALL be ROWS lines of COLS*BPP bits; contents not reset.
REQ-018 data SHALL present pixel (row,col) sampled at edge N from edge N+1 (1-cycle latency); old contents if that line is written at edge N.
REQ-019 row >= ROWS or col >= COLS SHALL read 0.
REQ-020 Write accepted at an edge where wr_valid && wr_ready.
REQ-021 Accepted write with rowW != row (same edge) SHALL commit to memory at that edge.
REQ-022 Accepted write with rowW == row SHALL be captured in a one-entry pending buffer (row+line), never dropped.
REQ-023 Pending entry SHALL commit at the first edge where row != pending row; buffer empties at that edge.
REQ-024 wr_ready SHALL equal (pending empty) && (state == IDLE); registered-state function only, no combinational path from wr_valid.
REQ-025 Accepted write with rowW >= ROWS SHALL be consumed and discarded.
REQ-026 State machine: IDLE, DRAIN, CLEAR.
REQ-027 IDLE + clear_req, pending empty -> CLEAR; pending full -> DRAIN.
REQ-028 DRAIN -> CLEAR at the edge the pending entry commits.
REQ-029 CLEAR: counter 0..ROWS-1 zeroes one line per cycle; after line ROWS-1 -> IDLE; exactly ROWS write cycles.
REQ-030 clear_busy SHALL be 1 in DRAIN and CLEAR; data SHALL read 0 while in CLEAR.
REQ-031 clear_req outside IDLE SHALL be ignored.
REQ-032 Simultaneous clear_req and accepted write in IDLE: write handled per REQ-021/022 first, then clear per REQ-027.

Reset
REQ-033 rstn low SHALL asynchronously set data=0, pending empty, state IDLE, clear counter 0, clear_busy=0; wr_ready=1 from first edge after release.
REQ-034 Reset mid-clear or with pending full SHALL abort; pending line lost; partially cleared memory left as is.

Configuration
REQ-035 Macro FBUF_CLEAR_EN defined: clear_req, DRAIN/CLEAR states and counter present as above.
REQ-036 FBUF_CLEAR_EN undefined: clear_req ignored, clear_busy tied 0, FSM permanently IDLE, wr_ready = pending empty; read/write behaviour identical.

Verification
REQ-037 Defaults; write rowW=5 line 0x1 (pixel 0 set) with row=10; then row=5,col=0 -> data=1 one cycle later, col=1 -> 0.
REQ-038 row=3 held, write rowW=3 pattern all-ones -> wr_ready 0 next cycle, data at (3,x) stays old; change row to 4 -> commit that edge, wr_ready 1 next cycle, (3,7) reads 1.
REQ-039 row=70 or col=90 -> data=0; write rowW=62 accepted, memory unchanged.
REQ-040 FBUF_CLEAR_EN, all lines all-ones, clear_req pulse -> clear_busy high exactly 60 cycles, wr_ready 0 throughout, then every pixel reads 0.
REQ-041 FBUF_CLEAR_EN, pending full (row=rowW=2), clear_req -> DRAIN until row changes, line 2 committed then zeroed, clear_busy 61+ cycles.
REQ-042 rstn low at clear cycle 20 -> data=0, clear_busy=0 immediately; lines 0..19 zero, 20..59 unchanged.
